seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Sequencer for the Basys3 4-digit, common-anode seven-segment display. It consumes the free-running 50 kHz scan_clk from the clock divider. It synchronizes scan_clk into the clk_100M domain and steps one digit per scan_clk rising edge. A programmable blanking gap between digits suppresses ghosting. Display data is double-buffered so a frame is never torn mid-scan.

Parameters:
NUM_DIG, 4, number of digits scanned (index 0 = rightmost, an[0], data_in[3:0]).
BLANK_CYC, 64, clk_100M cycles all anodes are off between digits; legal range 1..1000; must be shorter than the scan step interval.

Ports:
clk_100M  input  1  system clock, 100 MHz.
rst_n  input  1  asynchronous active-low reset.
scan_clk  input  1  50 kHz scan clock from the divider; treated as asynchronous.
data_in  input  16  four hex nibbles to display.
dp_in  input  4  decimal point per digit, 1 = lit.
dig_en  input  4  per-digit enable, 0 = digit kept dark.
load  input  1  1-cycle strobe: capture data_in/dp_in/dig_en into the pending buffer.
an  output  4  anode drives, active-low.
seg  output  7  segments a..g on bits 0..6, active-low.
dp  output  1  decimal point, active-low.
frame_done  output  1  1-cycle pulse when the digit index wraps NUM_DIG-1 -> 0.

Behaviour:
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_done = 0.
  - state = BLANK, idx = 0, blank counter = BLANK_CYC-1.
  - pending and active buffers = 0 with dig_en = 4'b0000, so the display is dark until the first load reaches active.
- Synchronizer and step pulse:
  - scan_clk passes through 2 flops (s1, s2) plus a history flop s3.
  - step = s2 & ~s3, one clk_100M cycle per scan_clk rising edge.
  - Latency from scan_clk edge to step: 2–3 cycles.
- Buffers:
  - When load = 1, pending <= {data_in, dp_in, dig_en}.
  - When idx wraps to 0, active <= pending.
  - If load and wrap occur in the same cycle, active takes the old pending and the new data lands in pending. It is displayed from the following frame.
- FSM states: BLANK, SHOW.
- BLANK:
  - an = 1111, seg = 1111111, dp = 1.
  - Counter decrements each cycle.
  - When the counter reaches 0, go to SHOW the next cycle.
  - step pulses arriving in BLANK are dropped, not queued.
- SHOW:
  - an[idx] = ~active.dig_en[idx]; all other an bits = 1.
  - seg = ~hexdecode(active nibble idx).
  - dp = ~active.dp[idx] when the digit is enabled; dp = 1 otherwise.
  - Outputs are registered and change on the cycle SHOW is entered.
  - On step: go to BLANK, reload counter to BLANK_CYC-1, idx <= (idx == NUM_DIG-1) ? 0 : idx+1.
  - On the wrap, frame_done = 1 for that single cycle.
- Hex decode, active-high pattern gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - The seg output is the bitwise inverse.
- Glitch rule: no cycle may have more than one an bit low. The an and seg outputs never change in the same cycle as a digit transition while any anode is low; BLANK always separates digits.
- Reset mid-scan: all outputs go dark immediately (asynchronously), and the buffers clear.
- scan_clk stuck at a level: no steps occur, and the current digit stays lit indefinitely. This is not an error.

Test Plan:
- Reset release, no load: for 10 scan periods, an = 1111, seg = 7F, dp = 1, and frame_done pulses once every 4 steps.
- load with data_in = 16'h12AF, dp_in = 4'b0100, dig_en = 4'hF, then run 2 frames:
  - Second frame shows an = 1110/seg = 0E, an = 1101/seg = 08, an = 1011/seg = 24 with dp = 0, an = 0111/seg = 79.
  - Each digit is preceded by exactly 64 cycles of an = 1111.
- dig_en = 4'b1010 with data 16'h8888: digits 0 and 2 keep an = 1111 throughout their slots; digits 1 and 3 show seg = 00.
- Mid-frame load of 16'hFFFF issued during digit 1 of a frame displaying 16'h0000: digits 2–3 of that frame still show 0 (seg = 40); the next frame shows F (seg = 0E).
- load coincident with the wrap cycle: the new value is absent for one whole frame and present in the frame after.
- rst_n pulsed low while in SHOW on digit 2: an = 1111 in the same cycle, and after release the display stays dark until a new load propagates.
- Scoreboard check across all tests: at most one an bit low in any cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scans a common-anode 7-seg display one digit per scan_clk edge,
// blanking between digits and swapping in double-buffered data at frame wrap.
module seg7_scan_ctrl #(
  parameter int NUM_DIG   = 4,
  parameter int BLANK_CYC = 64
) (
  input  logic                   clk_100M,
  input  logic                   rst_n,
  input  logic                   scan_clk,
  input  logic [4*NUM_DIG-1:0]   data_in,
  input  logic [NUM_DIG-1:0]     dp_in,
  input  logic [NUM_DIG-1:0]     dig_en,
  input  logic                   load,
  output logic [NUM_DIG-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   frame_done
);
  localparam int IW = NUM_DIG > 1 ? $clog2(NUM_DIG) : 1;
  localparam int CW = $clog2(BLANK_CYC + 1);
  localparam logic [15:0][6:0] HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {BLANK, SHOW} state_t;
  typedef struct packed {
    logic [4*NUM_DIG-1:0] data;
    logic [NUM_DIG-1:0]   dp;
    logic [NUM_DIG-1:0]   en;
  } buf_t;
  logic s1_q, s2_q, s3_q;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  buf_t pend_q, pend_d, act_q, act_d;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, fd_q;
  logic step, wrap, lit;
  logic [3:0] nib;
  assign step = s2_q & ~s3_q;
  assign wrap = state_q == SHOW && step && idx_q == IW'(NUM_DIG - 1);
  // Outputs are computed from next state so they switch exactly on entering SHOW/BLANK.
  always_comb begin
    state_d = state_q == BLANK ? (cnt_q == '0 ? SHOW : BLANK) : (step ? BLANK : SHOW);
    cnt_d = state_q == SHOW ? CW'(BLANK_CYC - 1) : cnt_q - 1'b1;
    idx_d = state_q == SHOW && step ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    pend_d = load ? {data_in, dp_in, dig_en} : pend_q;
    act_d = wrap ? pend_q : act_q;
    nib = act_d.data[idx_d*4 +: 4];
    lit = state_d == SHOW && act_d.en[idx_d];
    an_d = lit ? ~(NUM_DIG'(1) << idx_d) : '1;
    seg_d = lit ? ~HEX[nib] : '1;
    dp_d = ~(lit && act_d.dp[idx_d]);
  end
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      state_q <= BLANK;
      idx_q <= '0;
      cnt_q <= CW'(BLANK_CYC - 1);
      pend_q <= '0;
      act_q <= '0;
      an_q <= '1;
      seg_q <= '1;
      dp_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      s1_q <= scan_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      act_q <= act_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fd_q <= wrap;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign frame_done = fd_q;
endmodule
